id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage RV32I core with integrated load-use hazard detection.
//  Captures decoded controls, operands and register indices from ID each cycle; its ex_alu_op and
//  ex_funct outputs drive the EX-stage ALU control decoder directly. Inserts bubbles on load-use
//  hazards and branch flushes, and freezes on a back-end stall.
// PARAMETERS
//  XLEN   32  datapath width (pc, rs1/rs2 data, imm)
//  CNT_W  32  width of performance counters (PERF_CNT_EN only)
// PORTS
//  clk             in   1     single clock, rising edge
//  reset           in   1     synchronous, active-high
//  id_valid        in   1     ID holds a real instruction
//  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src  in  1 each  decoded controls
//  id_alu_op       in   2     00 add(ld/st), 01 sub(branch), 10 R-type decode
//  id_funct        in   4     {instr[30], instr[14:12]}
//  id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each
//  id_rs1, id_rs2, id_rd  in  5 each
//  flush           in   1     branch taken resolved in MEM; kill ID instruction
//  ex_hold         in   1     back-end stall; freeze ID/EX contents
//  ex_* (valid, reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, alu_op[2], funct[4],
//       pc, rs1_data, rs2_data, imm, rs1, rs2, rd)  out  registered copies of id_*
//  hazard_stall    out  1     combinational; deasserts PC write and IF/ID write
//  bubble_cnt      out  CNT_W bubbles inserted (PERF_CNT_EN only)
//  issue_cnt       out  CNT_W valid instructions loaded (PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: every ex_* output = 0 (ex_alu_op=2'b00, ex_funct=4'b0000); counters = 0.
//  - Latency: one cycle ID->EX on a load.
//  - hazard_stall = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ~flush & ~ex_hold
//      & ((ex_rd==id_rs1) | (ex_rd==id_rs2)). No registered state; rs usage not qualified.
//  - Per rising edge, priority (highest first):
//      1 reset    : clear all.
//      2 flush    : bubble (overrides ex_hold).
//      3 ex_hold  : all ex_* keep value; no counter change.
//      4 hazard_stall : bubble; ID instruction re-presented next cycle by stalled IF/ID.
//      5 else     : load all ex_* from id_*; ex_valid=id_valid.
//  - Bubble: ex_valid, reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src = 0;
//      alu_op=00, funct=0000; pc/data/imm/rs1/rs2/rd = 0. Bubble writes nothing, touches no memory.
//  - id_valid=0 on load yields ex_valid=0 but controls pass through; downstream gates on ex_valid.
//  - Reset mid-stall: hazard_stall drops the cycle after reset (ex_valid=0).
//  - Back-to-back loads to same rd: one bubble per dependent consumer only; never two consecutive
//      stalls for the same ID instruction (bubble clears ex_mem_read).
// CONFIGURATION
//  PERF_CNT_EN defined: bubble_cnt +1 on every bubble cycle (flush or hazard, not on reset/hold);
//    issue_cnt +1 on every load with id_valid=1; both wrap modulo 2^CNT_W.
//  PERF_CNT_EN undefined: ports bubble_cnt/issue_cnt absent, no counter logic.
// TESTING
//  T1 reset=1 two cycles with random id_* -> all ex_* = 0, hazard_stall=0, counters=0.
//  T2 load id_alu_op=10, id_funct=4'b1000, id_rd=5, id_pc=0x40 -> next cycle ex_alu_op=10,
//     ex_funct=1000, ex_rd=5, ex_pc=0x40, ex_valid=1.
//  T3 lw x5 in EX (ex_mem_read=1, ex_rd=5), ID add rs1=5 -> hazard_stall=1 same cycle; next edge
//     bubble (ex_valid=0, ex_mem_read=0); following edge add loads, hazard_stall=0.
//  T4 lw x0 in EX, ID rs1=0 -> hazard_stall=0; ID loads immediately.
//  T5 flush=1 with ex_hold=1 and hazard active -> bubble taken, hazard_stall=0, bubble_cnt +1.
//  T6 ex_hold=1 for 3 cycles with changing id_* -> ex_* unchanged; issue_cnt unchanged;
//     counter preloaded 0xFFFFFFFF wraps to 0 on next issue.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage RV32I core.
// Optional PERF_CNT_EN adds bubble/issue performance counters.
module id_ex_pipe_reg #(
   parameter int XLEN = 32
`ifdef PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic            id_reg_write,
   input  logic            id_mem_to_reg,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_branch,
   input  logic            id_alu_src,
   input  logic [1:0]      id_alu_op,
   input  logic [3:0]      id_funct,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic            flush,
   input  logic            ex_hold,
   output logic            ex_valid,
   output logic            ex_reg_write,
   output logic            ex_mem_to_reg,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_branch,
   output logic            ex_alu_src,
   output logic [1:0]      ex_alu_op,
   output logic [3:0]      ex_funct,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic            hazard_stall
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] issue_cnt
`endif
);

   typedef struct packed {
      logic            valid;
      logic            reg_write;
      logic            mem_to_reg;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            alu_src;
      logic [1:0]      alu_op;
      logic [3:0]      funct;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
   } stage_t;

   stage_t ex_q, ex_d, id_s;

   assign id_s = '{valid: id_valid, reg_write: id_reg_write, mem_to_reg: id_mem_to_reg,
                   mem_read: id_mem_read, mem_write: id_mem_write, branch: id_branch,
                   alu_src: id_alu_src, alu_op: id_alu_op, funct: id_funct, pc: id_pc,
                   rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                   rs1: id_rs1, rs2: id_rs2, rd: id_rd};

   // rs usage is not qualified by opcode: a false match only costs one bubble
   assign hazard_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid
                         & ~flush & ~ex_hold
                         & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2));

   always_comb begin
      ex_d = ex_q;
      if (flush)
         ex_d = '0;
      else if (ex_hold)
         ex_d = ex_q;
      else if (hazard_stall)
         ex_d = '0;
      else
         ex_d = id_s;
   end

   always_ff @(posedge clk) begin
      if (reset)
         ex_q <= '0;
      else
         ex_q <= ex_d;
   end

   assign ex_valid      = ex_q.valid;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_to_reg = ex_q.mem_to_reg;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_branch     = ex_q.branch;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_funct      = ex_q.funct;
   assign ex_pc         = ex_q.pc;
   assign ex_rs1_data   = ex_q.rs1_data;
   assign ex_rs2_data   = ex_q.rs2_data;
   assign ex_imm        = ex_q.imm;
   assign ex_rs1        = ex_q.rs1;
   assign ex_rs2        = ex_q.rs2;
   assign ex_rd         = ex_q.rd;

`ifdef PERF_CNT_EN
   logic             bubble_ev, issue_ev;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d, issue_cnt_q, issue_cnt_d;

   assign bubble_ev = flush | (~ex_hold & hazard_stall);
   assign issue_ev  = ~flush & ~ex_hold & ~hazard_stall & id_valid;

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      issue_cnt_d  = issue_cnt_q;
      if (bubble_ev)
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      if (issue_ev)
         issue_cnt_d = issue_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt_q <= '0;
         issue_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         issue_cnt_q  <= issue_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign issue_cnt  = issue_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed, table-driven bench for id_ex_pipe_reg; counter checks only when PERF_CNT_EN is defined.
module tb_id_ex_pipe_reg;

   localparam int XLEN = 32;
`ifdef PERF_CNT_EN
   localparam int CNT_W = 4;
`endif

   logic clk = 1'b0;
   logic reset;
   logic id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src;
   logic [1:0] id_alu_op;
   logic [3:0] id_funct;
   logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic flush, ex_hold;
   logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src;
   logic [1:0] ex_alu_op;
   logic [3:0] ex_funct;
   logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic hazard_stall;
`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt, issue_cnt;
`endif

   always #5 clk = ~clk;

   id_ex_pipe_reg #(
      .XLEN(XLEN)
`ifdef PERF_CNT_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_reg_write(id_reg_write),
      .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_branch(id_branch), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_funct(id_funct),
      .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush), .ex_hold(ex_hold),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .hazard_stall(hazard_stall)
`ifdef PERF_CNT_EN
      , .bubble_cnt(bubble_cnt), .issue_cnt(issue_cnt)
`endif
   );

   // ctl = {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src}
   localparam logic [5:0] LD = 6'b111001;
   localparam logic [5:0] AL = 6'b100000;
   localparam logic [5:0] ST = 6'b000101;
   localparam logic [5:0] BR = 6'b000010;

   typedef enum logic [1:0] {K_LOAD, K_BUB, K_HOLD} kind_e;

   typedef struct {
      kind_e       k;
      logic        v;
      logic [5:0]  ctl;
      logic [1:0]  op;
      logic [3:0]  fn;
      logic [31:0] pc, imm;
      logic [4:0]  rs1, rs2, rd;
      logic        fl, hd;
      logic        e_stall;
   } vec_t;

   typedef struct {
      logic        v;
      logic [5:0]  ctl;
      logic [1:0]  op;
      logic [3:0]  fn;
      logic [31:0] pc, imm;
      logic [4:0]  rs1, rs2, rd;
   } exp_t;

   localparam int NV = 20;
   vec_t vecs[NV];
   exp_t ex;
   int checks = 0;
   int errors = 0;

   function automatic vec_t mk(kind_e k, logic v, logic [5:0] ctl, logic [1:0] op, logic [3:0] fn,
                               logic [31:0] pc, logic [31:0] imm, logic [4:0] rs1, logic [4:0] rs2,
                               logic [4:0] rd, logic fl, logic hd, logic stall);
      vec_t r;
      r.k = k; r.v = v; r.ctl = ctl; r.op = op; r.fn = fn; r.pc = pc; r.imm = imm;
      r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.fl = fl; r.hd = hd; r.e_stall = stall;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      id_valid = t.v;
      {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src} = t.ctl;
      id_alu_op = t.op; id_funct = t.fn; id_pc = t.pc; id_imm = t.imm;
      id_rs1_data = t.pc + t.imm;
      id_rs2_data = t.pc - t.imm;
      id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
      flush = t.fl; ex_hold = t.hd;
   endtask

   task automatic drive_random();
      id_valid = 1'($urandom);
      {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src} = 6'($urandom);
      id_alu_op = 2'($urandom); id_funct = 4'($urandom);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_rd = 5'($urandom);
      flush = 1'($urandom); ex_hold = 1'($urandom);
   endtask

   task automatic cmp_ex(input string tag, input exp_t e);
      chk({tag, " ex_valid"}, 32'(ex_valid), 32'(e.v));
      chk({tag, " ex_ctl"}, 32'({ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                                 ex_branch, ex_alu_src}), 32'(e.ctl));
      chk({tag, " ex_alu_op"}, 32'(ex_alu_op), 32'(e.op));
      chk({tag, " ex_funct"}, 32'(ex_funct), 32'(e.fn));
      chk({tag, " ex_pc"}, ex_pc, e.pc);
      chk({tag, " ex_imm"}, ex_imm, e.imm);
      chk({tag, " ex_rs1_data"}, ex_rs1_data, e.pc + e.imm);
      chk({tag, " ex_rs2_data"}, ex_rs2_data, e.pc - e.imm);
      chk({tag, " ex_rs1"}, 32'(ex_rs1), 32'(e.rs1));
      chk({tag, " ex_rs2"}, 32'(ex_rs2), 32'(e.rs2));
      chk({tag, " ex_rd"}, 32'(ex_rd), 32'(e.rd));
   endtask

   initial begin
      vecs[0]  = mk(K_LOAD, 1, AL, 2'b10, 4'b1000, 32'h40, 32'h0,  5'd1,  5'd2,  5'd5,  0, 0, 0);
      vecs[1]  = mk(K_LOAD, 1, LD, 2'b00, 4'b0010, 32'h44, 32'h8,  5'd2,  5'd0,  5'd5,  0, 0, 0);
      vecs[2]  = mk(K_BUB,  1, AL, 2'b10, 4'b0000, 32'h48, 32'h0,  5'd5,  5'd3,  5'd6,  0, 0, 1);
      vecs[3]  = mk(K_LOAD, 1, AL, 2'b10, 4'b0000, 32'h48, 32'h0,  5'd5,  5'd3,  5'd6,  0, 0, 0);
      vecs[4]  = mk(K_LOAD, 1, LD, 2'b00, 4'b0010, 32'h4C, 32'h4,  5'd1,  5'd0,  5'd0,  0, 0, 0);
      vecs[5]  = mk(K_LOAD, 1, BR, 2'b01, 4'b0000, 32'h50, 32'h10, 5'd0,  5'd0,  5'd0,  0, 0, 0);
      vecs[6]  = mk(K_LOAD, 1, LD, 2'b00, 4'b0010, 32'h54, 32'hC,  5'd2,  5'd0,  5'd7,  0, 0, 0);
      vecs[7]  = mk(K_BUB,  1, AL, 2'b10, 4'b0000, 32'h58, 32'h0,  5'd3,  5'd7,  5'd8,  1, 1, 0);
      vecs[8]  = mk(K_LOAD, 0, ST, 2'b00, 4'b0010, 32'h5C, 32'h20, 5'd1,  5'd2,  5'd0,  0, 0, 0);
      vecs[9]  = mk(K_LOAD, 1, LD, 2'b00, 4'b0010, 32'h60, 32'h4,  5'd1,  5'd0,  5'd9,  0, 0, 0);
      vecs[10] = mk(K_HOLD, 1, AL, 2'b10, 4'b0000, 32'h64, 32'h0,  5'd9,  5'd1,  5'd10, 0, 1, 0);
      vecs[11] = mk(K_HOLD, 1, ST, 2'b00, 4'b0010, 32'h68, 32'h30, 5'd4,  5'd9,  5'd0,  0, 1, 0);
      vecs[12] = mk(K_HOLD, 0, BR, 2'b01, 4'b1000, 32'h6C, 32'h40, 5'd9,  5'd9,  5'd3,  0, 1, 0);
      vecs[13] = mk(K_BUB,  1, AL, 2'b10, 4'b0000, 32'h70, 32'h0,  5'd9,  5'd1,  5'd10, 0, 0, 1);
      vecs[14] = mk(K_LOAD, 1, AL, 2'b10, 4'b0000, 32'h70, 32'h0,  5'd9,  5'd1,  5'd10, 0, 0, 0);
      vecs[15] = mk(K_LOAD, 1, LD, 2'b00, 4'b0010, 32'h74, 32'h0,  5'd1,  5'd0,  5'd11, 0, 0, 0);
      vecs[16] = mk(K_BUB,  1, LD, 2'b00, 4'b0010, 32'h78, 32'h0,  5'd11, 5'd0,  5'd11, 0, 0, 1);
      vecs[17] = mk(K_LOAD, 1, LD, 2'b00, 4'b0010, 32'h78, 32'h0,  5'd11, 5'd0,  5'd11, 0, 0, 0);
      vecs[18] = mk(K_BUB,  1, AL, 2'b10, 4'b0000, 32'h7C, 32'h0,  5'd1,  5'd11, 5'd12, 0, 0, 1);
      vecs[19] = mk(K_LOAD, 1, AL, 2'b10, 4'b0000, 32'h7C, 32'h0,  5'd1,  5'd11, 5'd12, 0, 0, 0);

      // Reset held two cycles with random ID inputs
      reset = 1'b1;
      drive_random();
      @(posedge clk);
      @(negedge clk);
      drive_random();
      @(posedge clk);
      #1;
      ex = '{v: 0, ctl: 0, op: 0, fn: 0, pc: 0, imm: 0, rs1: 0, rs2: 0, rd: 0};
      cmp_ex("reset", ex);
      chk("reset hazard_stall", 32'(hazard_stall), 32'd0);
`ifdef PERF_CNT_EN
      chk("reset bubble_cnt", 32'(bubble_cnt), 32'd0);
      chk("reset issue_cnt", 32'(issue_cnt), 32'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d hazard_stall", i), 32'(hazard_stall), 32'(vecs[i].e_stall));
         @(posedge clk);
         #1;
         case (vecs[i].k)
            K_LOAD: ex = '{v: vecs[i].v, ctl: vecs[i].ctl, op: vecs[i].op, fn: vecs[i].fn,
                           pc: vecs[i].pc, imm: vecs[i].imm, rs1: vecs[i].rs1,
                           rs2: vecs[i].rs2, rd: vecs[i].rd};
            K_BUB:  ex = '{v: 0, ctl: 0, op: 0, fn: 0, pc: 0, imm: 0, rs1: 0, rs2: 0, rd: 0};
            default: ;
         endcase
         cmp_ex($sformatf("v%0d", i), ex);
      end
`ifdef PERF_CNT_EN
      chk("table bubble_cnt", 32'(bubble_cnt), 32'd5);
      chk("table issue_cnt", 32'(issue_cnt), 32'd11);
`endif

      // Reset while a load-use stall is pending
      @(negedge clk);
      drive(mk(K_LOAD, 1, LD, 2'b00, 4'b0010, 32'h80, 32'h0, 5'd1, 5'd0, 5'd5, 0, 0, 0));
      @(posedge clk);
      @(negedge clk);
      drive(mk(K_LOAD, 1, AL, 2'b10, 4'b0000, 32'h84, 32'h0, 5'd5, 5'd2, 5'd6, 0, 0, 0));
      #1;
      chk("midrst stall before", 32'(hazard_stall), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst ex_valid", 32'(ex_valid), 32'd0);
      chk("midrst ex_mem_read", 32'(ex_mem_read), 32'd0);
      chk("midrst hazard_stall", 32'(hazard_stall), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst reload ex_pc", ex_pc, 32'h84);
      chk("midrst reload ex_valid", 32'(ex_valid), 32'd1);

`ifdef PERF_CNT_EN
      // Issue counter wrap after reset: 1 issue above, then 15 more wraps a 4-bit counter to 0
      chk("wrap start issue_cnt", 32'(issue_cnt), 32'd1);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(mk(K_LOAD, 1, AL, 2'b10, 4'b0000, 32'h100 + 32'(i), 32'h0, 5'd0, 5'd0, 5'd1, 0, 0, 0));
         @(posedge clk);
         #1;
         if (i == 13) chk("wrap issue_cnt max", 32'(issue_cnt), 32'd15);
      end
      chk("wrap issue_cnt zero", 32'(issue_cnt), 32'd0);
      chk("wrap bubble_cnt", 32'(bubble_cnt), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
